// File: rtl/button_pulse_generator.sv
// Purpose : debounce two raw pushbuttons (UP/DOWN) and turn presses into one-cycle
//           count commands, with optional auto-repeat while a button is held.
// Latency : first pulse DEBOUNCE_CYCLES+3 edges after btn is first sampled high.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   btn_up     - raw UP button (asynchronous, bouncy, active-high)
//   btn_down   - raw DOWN button (asynchronous, bouncy, active-high)
//   up_pulse   - registered one-cycle UP command
//   down_pulse - registered one-cycle DOWN command
//   up_level   - debounced UP level
//   down_level - debounced DOWN level
module button_pulse_generator #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_EN       = 1,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_level,
  output logic down_level
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Channel 0 is UP, channel 1 is DOWN.
  logic [1:0] btn_raw;
  logic [1:0] level_vec;
  logic [1:0] pulse_vec;

  assign btn_raw = {btn_down, btn_up};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             level;
    logic [CNT_W-1:0] db_cnt;
    logic             oth;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_n;
    logic             pulse;
    logic             pulse_n;

    // Two-flop synchronizer; nothing downstream looks at s1 or the raw pin.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= btn_raw[ch];
        s2 <= s1;
      end
    end

    // The level only follows s2 after DEBOUNCE_CYCLES consecutive mismatching
    // cycles; any agreement in between restarts the count.
    always_ff @(posedge clk) begin
      if (reset) begin
        level  <= 1'b0;
        db_cnt <= '0;
      end else if (s2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end

    assign level_vec[ch] = level;

    if (ch == 0) begin : g_oth_up
      assign oth = level_vec[1];
    end else begin : g_oth_down
      assign oth = level_vec[0];
    end

    // Both buttons down is ambiguous, so it wins over everything and parks the
    // channel in LOCKED until its own button is released.
    always_comb begin
      state_n = state;
      timer_n = timer;
      pulse_n = 1'b0;
      if (level && oth) begin
        state_n = LOCKED;
        timer_n = '0;
      end else begin
        case (state)
          IDLE: begin
            if (level) begin
              pulse_n = 1'b1;
              timer_n = '0;
              state_n = DELAY;
            end
          end
          DELAY: begin
            if (!level) begin
              timer_n = '0;
              state_n = IDLE;
            end else if (REPEAT_EN != 0) begin
              if (timer == DELAY_LAST) begin
                pulse_n = 1'b1;
                timer_n = '0;
                state_n = REPEAT;
              end else begin
                timer_n = timer + CNT_ONE;
              end
            end
          end
          REPEAT: begin
            if (!level) begin
              timer_n = '0;
              state_n = IDLE;
            end else if (timer == PERIOD_LAST) begin
              pulse_n = 1'b1;
              timer_n = '0;
            end else begin
              timer_n = timer + CNT_ONE;
            end
          end
          LOCKED: begin
            if (!level) begin
              timer_n = '0;
              state_n = IDLE;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        timer <= '0;
        pulse <= 1'b0;
      end else begin
        state <= state_n;
        timer <= timer_n;
        pulse <= pulse_n;
      end
    end

    assign pulse_vec[ch] = pulse;
  end

  assign up_pulse   = pulse_vec[0];
  assign down_pulse = pulse_vec[1];
  assign up_level   = level_vec[0];
  assign down_level = level_vec[1];

endmodule

// File: tb/tb_button_pulse_generator.sv
// Purpose : self-checking bench for button_pulse_generator (D=4, delay 10, period 3).
// Latency : index i = number of rising edges since the sequence started; inputs for
//           edge i are driven and outputs for index i are sampled on the preceding negedge.
// Backpressure: n/a.
module tb_button_pulse_generator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_up2 = 1'b0;
  logic btn_down2 = 1'b0;
  logic up_pulse, down_pulse, up_level, down_level;
  logic up_pulse2, down_pulse2, up_level2, down_level2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_pulse_generator #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .up_level(up_level), .down_level(down_level)
  );

  button_pulse_generator #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(0), .CNT_W(8)
  ) dut_norep (
    .clk(clk), .reset(reset), .btn_up(btn_up2), .btn_down(btn_down2),
    .up_pulse(up_pulse2), .down_pulse(down_pulse2), .up_level(up_level2), .down_level(down_level2)
  );

  // Field order: btn_up btn_down | up_pulse down_pulse up_level down_level
  typedef struct packed {
    logic bu;
    logic bd;
    logic eup;
    logic edn;
    logic elu;
    logic eld;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s i=%0d got=%b expected=%b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int i, input logic eup, input logic edn,
                           input logic elu, input logic eld);
    chk({tag, ".up_pulse"}, i, up_pulse, eup);
    chk({tag, ".down_pulse"}, i, down_pulse, edn);
    chk({tag, ".up_level"}, i, up_level, elu);
    chk({tag, ".down_level"}, i, down_level, eld);
    chk({tag, ".pulse_excl"}, i, up_pulse & down_pulse, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called on a negedge; leaves reset low on a negedge with all buttons released.
  task automatic do_reset();
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_up2 = 1'b0;
    btn_down2 = 1'b0;
    reset = 1'b1;
    step();
    step();
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.up_pulse2", 0, up_pulse2, 1'b0);
    chk("reset.down_pulse2", 0, down_pulse2, 1'b0);
    chk("reset.up_level2", 0, up_level2, 1'b0);
    chk("reset.down_level2", 0, down_level2, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // Clean press: held for edges 0..7. Level up for indices 6..13, one pulse at 7.
    for (int i = 0; i < 6; i++) tbl.push_back(6'b10_00_00);
    tbl.push_back(6'b10_00_10);
    tbl.push_back(6'b10_10_10);
    for (int i = 8; i < 14; i++) tbl.push_back(6'b00_00_10);
    for (int i = 14; i < 20; i++) tbl.push_back(6'b00_00_00);
    // Bounce 1,0,1,0 then quiet: nothing may happen.
    tbl.push_back(6'b10_00_00);
    tbl.push_back(6'b00_00_00);
    tbl.push_back(6'b10_00_00);
    for (int i = 0; i < 7; i++) tbl.push_back(6'b00_00_00);
    // Three-cycle glitch is one short of the debounce window.
    for (int i = 0; i < 3; i++) tbl.push_back(6'b10_00_00);
    for (int i = 0; i < 9; i++) tbl.push_back(6'b00_00_00);

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      btn_up = tbl[i].bu;
      btn_down = tbl[i].bd;
      check_all("table", i, tbl[i].eup, tbl[i].edn, tbl[i].elu, tbl[i].eld);
      step();
    end

    // Down held for 40 edges: first pulse at 7, first repeat at 17, then every 3.
    do_reset();
    for (int i = 0; i < 56; i++) begin
      btn_down = (i < 40);
      check_all("hold", i, 1'b0,
                (i == 7) || (i >= 17 && i <= 44 && (i - 17) % 3 == 0),
                1'b0, (i >= 6 && i <= 45));
      step();
    end

    // Lockout: up from 0..39, down from 22..59 and again from 72.
    do_reset();
    for (int i = 0; i < 86; i++) begin
      btn_up = (i < 40);
      btn_down = (i >= 22 && i < 60) || (i >= 72);
      check_all("lock", i,
                (i == 7) || (i == 17) || (i == 20) || (i == 23) || (i == 26),
                (i == 79),
                (i >= 6 && i <= 45),
                (i >= 28 && i <= 65) || (i >= 78));
      step();
    end

    // Reset for edges 25 and 26 while up is repeating; edge 27 restarts the press.
    do_reset();
    for (int i = 0; i < 46; i++) begin
      btn_up = 1'b1;
      reset = (i == 25) || (i == 26);
      check_all("rst_hold", i,
                (i < 26) ? ((i == 7) || (i == 17) || (i == 20) || (i == 23)) : (i == 34 || i == 44),
                1'b0,
                (i < 26) ? (i >= 6) : (i >= 33),
                1'b0);
      step();
    end
    reset = 1'b0;

    // No auto-repeat: one pulse per press, second press at 60.
    do_reset();
    for (int i = 0; i < 76; i++) begin
      btn_up2 = (i < 50) || (i >= 60);
      chk("norep.up_pulse", i, up_pulse2, (i == 7) || (i == 67));
      chk("norep.up_level", i, up_level2, (i >= 6 && i <= 55) || (i >= 66));
      chk("norep.down_pulse", i, down_pulse2, 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
